// File: rtl/os_drain_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : os_drain_collector_if
// Brief    : Drain-side capture and result-stream signals of os_drain_collector.
// Revision : 1.0
// ============================================================================
interface os_drain_collector_if #(
  parameter int D_W  = 8,
  parameter int ROWS = 4
);
  localparam int RW = $clog2(ROWS);

  logic [2*D_W-1:0] in_data;
  logic             in_valid;
  logic [2*D_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [RW-1:0]    m_row;
  logic             m_last;

  modport master (
    output in_data, in_valid, m_ready,
    input  m_data, m_valid, m_row, m_last
  );

  modport slave (
    input  in_data, in_valid, m_ready,
    output m_data, m_valid, m_row, m_last
  );
endinterface
`default_nettype wire

// File: rtl/os_drain_collector.sv
`default_nettype none
// ============================================================================
// Module   : os_drain_collector
// Brief    : Column-bottom psum drain receiver; row/frame tagging, FIFO, overflow.
//            Row tagging and frame counting are built only with OS_DRAIN_ROWTAG_EN.
// Revision : 1.0
// ============================================================================
module os_drain_collector #(
  parameter int D_W   = 8,
  parameter int ROWS  = 4,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  os_drain_collector_if.slave bus,
  input  logic                clr_ovf,
  output logic                overflow,
  output logic [15:0]         frame_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(ROWS);
  localparam int DW = 2 * D_W;

  logic [DW-1:0] data_mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          ovf_q;
  logic          ovf_d;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign pop    = !empty && bus.m_ready;
  // The drain chain cannot stall, so a full FIFO only accepts if the head leaves now.
  assign push   = bus.in_valid && (!full || pop);
  assign drop   = bus.in_valid && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        data_mem_q[wr_idx] <= bus.in_data;
        wr_ptr_q           <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.m_valid = !empty;
  assign bus.m_data  = data_mem_q[rd_idx];
  assign overflow    = ovf_q;

`ifdef OS_DRAIN_ROWTAG_EN
  logic [RW-1:0] row_mem_q  [DEPTH];
  logic          last_mem_q [DEPTH];
  logic [RW-1:0] rc_q;
  logic [RW-1:0] rc_d;
  logic [15:0]   frame_cnt_q;
  logic [15:0]   frame_cnt_d;

  // Tags advance on every drain word, dropped or not, to keep frame alignment.
  always_comb begin
    rc_d        = rc_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.in_valid) begin
      rc_d = (rc_q == '0) ? RW'(ROWS - 1) : rc_q - RW'(1);
      if (rc_q == '0) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q        <= RW'(ROWS - 1);
      frame_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        row_mem_q[i]  <= '0;
        last_mem_q[i] <= 1'b0;
      end
    end else begin
      rc_q        <= rc_d;
      frame_cnt_q <= frame_cnt_d;
      if (push) begin
        row_mem_q[wr_idx]  <= rc_q;
        last_mem_q[wr_idx] <= (rc_q == '0);
      end
    end
  end

  assign bus.m_row  = row_mem_q[rd_idx];
  assign bus.m_last = last_mem_q[rd_idx];
  assign frame_cnt  = frame_cnt_q;
`else
  assign bus.m_row  = {RW{1'b0}};
  assign bus.m_last = 1'b0;
  assign frame_cnt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_os_drain_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_drain_collector
// Brief    : Scoreboard bench for os_drain_collector (works with OS_DRAIN_ROWTAG_EN on or off).
// Revision : 1.0
// ============================================================================
module tb_os_drain_collector;
  localparam int D_W   = 8;
  localparam int ROWS  = 4;
  localparam int DEPTH = 8;
`ifdef OS_DRAIN_ROWTAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        clr_ovf = 1'b0;
  logic        overflow;
  logic [15:0] frame_cnt;

  os_drain_collector_if #(.D_W(D_W), .ROWS(ROWS)) bus ();

  os_drain_collector #(.D_W(D_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_ovf   (clr_ovf),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  row;
    logic        last;
    int          t;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_fc(input int n);
    return TAG ? 32'(n) : 32'd0;
  endfunction

  // Caller sits at posedge+1; the word is presented for exactly one edge.
  task automatic drive(input logic [15:0] d, input int row, input bit acc);
    exp_t e;
    e.d    = d;
    e.row  = TAG ? 2'(row) : 2'd0;
    e.last = TAG && (row == 0);
    e.t    = cyc;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    if (acc) sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got data 0x%0h, expected no output (t=%0t)", bus.m_data, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pop_data", 32'(bus.m_data), 32'(mon_e.d));
        chk("pop_row",  32'(bus.m_row),  32'(mon_e.row));
        chk("pop_last", 32'(bus.m_last), 32'(mon_e.last));
        if (lat_chk) chk("pop_latency", 32'(cyc), 32'(mon_e.t + 1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.m_ready  = 1'b0;
    repeat (2) @(posedge clk); #1;

    chk("rst_m_valid",   32'(bus.m_valid), 32'd0);
    chk("rst_m_data",    32'(bus.m_data),  32'd0);
    chk("rst_m_row",     32'(bus.m_row),   32'd0);
    chk("rst_m_last",    32'(bus.m_last),  32'd0);
    chk("rst_overflow",  32'(overflow),    32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame tagging, streaming with m_ready high
    bus.m_ready = 1'b1;
    lat_chk     = 1'b1;
    drive(16'h0011, 3, 1'b1);
    drive(16'h0022, 2, 1'b1);
    drive(16'h0033, 1, 1'b1);
    drive(16'h0044, 0, 1'b1);
    @(posedge clk); #1;
    chk("frame_sb_empty",  32'(sb_q.size()),  32'd0);
    chk("frame_m_valid",   32'(bus.m_valid),  32'd0);
    chk("frame_cnt_1",     32'(frame_cnt),    exp_fc(1));
    lat_chk     = 1'b0;
    bus.m_ready = 1'b0;

    // Backpressure: fill all eight entries
    drive(16'h0011, 3, 1'b1);
    drive(16'h0022, 2, 1'b1);
    drive(16'h0033, 1, 1'b1);
    drive(16'h0044, 0, 1'b1);
    drive(16'h0055, 3, 1'b1);
    drive(16'h0066, 2, 1'b1);
    drive(16'h0077, 1, 1'b1);
    drive(16'h0088, 0, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("bp_m_valid",   32'(bus.m_valid), 32'd1);
    chk("bp_head_data", 32'(bus.m_data),  32'h0011);
    chk("bp_head_row",  32'(bus.m_row),   TAG ? 32'd3 : 32'd0);
    chk("bp_overflow",  32'(overflow),    32'd0);
    chk("bp_frame_cnt", 32'(frame_cnt),   exp_fc(3));

    // Overflow and clear precedence
    drive(16'h00FF, 3, 1'b0);
    chk("ovf_set",       32'(overflow),   32'd1);
    chk("ovf_head_kept", 32'(bus.m_data), 32'h0011);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    drive(16'h0099, 2, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared_2", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    bus.m_ready = 1'b1;
    drive(16'h0055, 1, 1'b1);
    bus.m_ready = 1'b0;
    chk("fullpp_overflow",  32'(overflow),    32'd0);
    chk("fullpp_head",      32'(bus.m_data),  32'h0022);
    chk("fullpp_frame_cnt", 32'(frame_cnt),   exp_fc(3));

    bus.m_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk); #1;
      if (!bus.m_valid) drained = 1'b1;
    end
    chk("drain_done",     32'(drained),     32'd1);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    bus.m_ready = 1'b0;

    // Asynchronous reset mid-frame
    drive(16'h00A1, 0, 1'b1);
    drive(16'h00A2, 3, 1'b1);
    chk("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid",   32'(bus.m_valid), 32'd0);
    chk("async_rst_frame_cnt", 32'(frame_cnt),   32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    lat_chk     = 1'b1;
    drive(16'h0066, 3, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_sb_empty",  32'(sb_q.size()), 32'd0);
    chk("post_rst_frame_cnt", 32'(frame_cnt),   32'd0);
    lat_chk     = 1'b0;
    bus.m_ready = 1'b0;

    repeat (2) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
